exec_muldiv: RTL

Parametrised multi-cycle execute unit for the integer multiply/divide group (RISC-V M ops). It sits beside the single-cycle execute path in the EX stage. It accepts one operation through an `enable`/`fin` handshake, iterates one bit per cycle, and returns the result with its destination register. Unlike the single-cycle path, `fin` is a real completion strobe: the pipeline holds EX while `busy` is high and can abort an in-flight operation with `flush`.

---
 rtl/exec_muldiv.sv | 129 ++++++++++++
 1 files changed

// File: rtl/exec_muldiv.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide, one bit per cycle.
// Latency XLEN+1 cycles (1 for divide-by-zero/overflow); new starts are taken only in IDLE/DONE, dropped while busy.
module exec_muldiv #(
    parameter int XLEN = 32,
    parameter int RDW  = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src0,
    input  logic [XLEN-1:0] src1,
    input  logic [RDW-1:0]  rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            fin,
    output logic [XLEN-1:0] result,
    output logic [RDW-1:0]  rd,
    output logic            regwrite
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [CW-1:0]       cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     b_q;
    logic [XLEN-1:0]     result_q;
    logic [RDW-1:0]      rd_pend_q;
    logic [RDW-1:0]      rd_q;

    // Start decode: operand magnitudes, result sign and single-cycle divide cases.
    logic            is_div, is_rem, s0_signed, s1_signed, neg0, neg1;
    logic [XLEN-1:0] mag0, mag1, special_res;
    logic            div_zero, div_ovf, start_neg;

    always_comb begin
        is_div      = op[2];
        is_rem      = op[1];
        s0_signed   = is_div ? ~op[0] : (op[1:0] != 2'b11);
        s1_signed   = is_div ? ~op[0] : ~op[1];
        neg0        = s0_signed & src0[XLEN-1];
        neg1        = s1_signed & src1[XLEN-1];
        mag0        = neg0 ? -src0 : src0;
        mag1        = neg1 ? -src1 : src1;
        start_neg   = (is_div && is_rem) ? neg0 : (neg0 ^ neg1);
        div_zero    = is_div && (src1 == '0);
        div_ovf     = is_div && ~op[0] && (src0 == {1'b1, {(XLEN-1){1'b0}}}) && (src1 == '1);
        special_res = div_zero ? (is_rem ? src0 : '1) : (is_rem ? '0 : src0);
    end

    // One iteration: acc holds {partial/remainder, multiplier/dividend bits}.
    logic [XLEN:0]       msum, trial, diff;
    logic                ge;
    logic [XLEN-1:0]     rem_new, div_sel, div_res, mul_res, final_res;
    logic [2*XLEN-1:0]   iter, prod_fix;

    always_comb begin
        msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        trial    = acc_q[2*XLEN-1:XLEN-1];
        diff     = trial - {1'b0, b_q};
        ge       = trial >= {1'b0, b_q};
        rem_new  = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
        iter     = op_q[2] ? {rem_new, acc_q[XLEN-2:0], ge} : {msum, acc_q[XLEN-1:1]};
        prod_fix = neg_q ? -iter : iter;
        mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        div_sel  = op_q[1] ? iter[2*XLEN-1:XLEN] : iter[XLEN-1:0];
        div_res  = neg_q ? -div_sel : div_sel;
        final_res = op_q[2] ? div_res : mul_res;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            result_q  <= '0;
            rd_pend_q <= '0;
            rd_q      <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (enable) begin
                        op_q      <= op;
                        neg_q     <= start_neg;
                        rd_pend_q <= rd_in;
                        acc_q     <= {{XLEN{1'b0}}, is_div ? mag0 : mag1};
                        b_q       <= is_div ? mag1 : mag0;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            rd_q     <= rd_in;
                            state_q  <= DONE;
                        end else begin
                            cnt_q   <= CW'(XLEN-1);
                            state_q <= RUN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= iter;
                    if (cnt_q == '0) begin
                        result_q <= final_res;
                        rd_q     <= rd_pend_q;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == RUN);
    assign fin      = (state_q == DONE);
    assign result   = result_q;
    assign rd       = rd_q;
    assign regwrite = fin && (rd_q != '0);
endmodule
